// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port 1K x 32 byte-enabled RAM between two requesters
//   that use the core's strobe/busy memory protocol: port 0 is the RISC-V
//   core, port 1 is the PIM compute engine. Each port's request is latched,
//   the two are arbitrated (round-robin or fixed priority) and issued to the
//   RAM one access at a time.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   pN_addr/wdata/wmask     byte address, write data, byte write mask (write strobe)
//   pN_rstrb                read strobe (single-cycle pulse)
//   pN_rdata                registered read data, held until the port's next read completes
//   pN_rbusy / pN_wbusy     read / write pending on that port
//   ram_addr/wdata/wen/rden/byteena   RAM command, held between accesses
//   ram_rdata               RAM read data, RD_LATENCY cycles after ram_rden
//   grant                   one-hot owner of the current access, 0 when idle
//   oob_err                 one-cycle pulse after an out-of-range access completes
module ram_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int RD_LATENCY = 1,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       p0_addr,
   input  logic [31:0]       p0_wdata,
   input  logic [3:0]        p0_wmask,
   input  logic              p0_rstrb,
   output logic [31:0]       p0_rdata,
   output logic              p0_rbusy,
   output logic              p0_wbusy,
   input  logic [31:0]       p1_addr,
   input  logic [31:0]       p1_wdata,
   input  logic [3:0]        p1_wmask,
   input  logic              p1_rstrb,
   output logic [31:0]       p1_rdata,
   output logic              p1_rbusy,
   output logic              p1_wbusy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_wen,
   output logic              ram_rden,
   output logic [3:0]        ram_byteena,
   input  logic [31:0]       ram_rdata,
   output logic [1:0]        grant,
   output logic              oob_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RD_WAIT} state_t;

   state_t r_state, w_next;

   // per-port inputs gathered into arrays so capture logic is written once
   logic [1:0][31:0] w_in_addr, w_in_wdata;
   logic [1:0][3:0]  w_in_wmask;
   logic [1:0]       w_in_rstrb;

   // latched requests
   logic [1:0][31:0] r_addr, r_wdata, r_rdata;
   logic [1:0][3:0]  r_wmask;
   logic [1:0]       r_pend, r_wr;

   logic             r_sel;    // port owning the current access
   logic             r_last;   // port granted most recently (round-robin pointer)
   logic [1:0]       r_grant;
   logic [1:0]       r_cnt;
   logic             r_oob;

   logic [ADDR_W-1:0] r_ram_addr;
   logic [31:0]       r_ram_wdata;
   logic [3:0]        r_ram_byteena;
   logic              r_ram_wen, r_ram_rden;

   logic w_pick, w_pick_oob, w_sel_oob;
   logic w_unused;

   assign w_in_addr  = {p1_addr,  p0_addr};
   assign w_in_wdata = {p1_wdata, p0_wdata};
   assign w_in_wmask = {p1_wmask, p0_wmask};
   assign w_in_rstrb = {p1_rstrb, p0_rstrb};

   // byte-offset bits never reach the word-addressed RAM
   assign w_unused = ^{r_addr[0][1:0], r_addr[1][1:0]};

   // arbitration: a lone requester wins; on a tie the port not served last
   // wins, or port 0 always when FIXED_PRIO is set
   always_comb begin
      w_pick = 1'b0;
      if (r_pend == 2'b11)
         w_pick = FIXED_PRIO ? 1'b0 : ~r_last;
      else if (r_pend[1])
         w_pick = 1'b1;
   end

   assign w_pick_oob = |r_addr[w_pick][31:ADDR_W+2];
   assign w_sel_oob  = |r_addr[r_sel][31:ADDR_W+2];

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (|r_pend) w_next = S_ACCESS;
         // writes and out-of-range reads finish in ACCESS
         S_ACCESS:  w_next = (r_wr[r_sel] || w_sel_oob) ? S_IDLE : S_RD_WAIT;
         S_RD_WAIT: if (r_cnt == 2'd1) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wmask       <= '0;
         r_rdata       <= '0;
         r_pend        <= '0;
         r_wr          <= '0;
         r_sel         <= 1'b0;
         r_last        <= 1'b1;
         r_grant       <= '0;
         r_cnt         <= '0;
         r_oob         <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_wdata   <= '0;
         r_ram_byteena <= '0;
         r_ram_wen     <= 1'b0;
         r_ram_rden    <= 1'b0;
      end else begin
         r_oob      <= 1'b0;
         r_ram_wen  <= 1'b0;
         r_ram_rden <= 1'b0;

         // capture: strobes arriving while a port is pending are dropped;
         // a write mask wins over a simultaneous read strobe
         for (int p = 0; p < 2; p++) begin
            if (!r_pend[p] && (w_in_wmask[p] != 4'b0 || w_in_rstrb[p])) begin
               r_addr[p]  <= w_in_addr[p];
               r_wdata[p] <= w_in_wdata[p];
               r_wmask[p] <= w_in_wmask[p];
               r_wr[p]    <= |w_in_wmask[p];
               r_pend[p]  <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (|r_pend) begin
                  r_sel         <= w_pick;
                  r_last        <= w_pick;
                  r_grant       <= w_pick ? 2'b10 : 2'b01;
                  // RAM command is registered here so it is live exactly
                  // during ACCESS and holds its value afterwards
                  r_ram_addr    <= r_addr[w_pick][ADDR_W+1:2];
                  r_ram_wdata   <= r_wdata[w_pick];
                  r_ram_byteena <= r_wr[w_pick] ? r_wmask[w_pick] : 4'hF;
                  r_ram_wen     <= r_wr[w_pick] & ~w_pick_oob;
                  r_ram_rden    <= ~r_wr[w_pick] & ~w_pick_oob;
               end
            end
            S_ACCESS: begin
               r_cnt <= 2'(RD_LATENCY);
               if (r_wr[r_sel] || w_sel_oob) begin
                  r_pend[r_sel] <= 1'b0;
                  r_grant       <= '0;
                  r_oob         <= w_sel_oob;
                  if (!r_wr[r_sel]) r_rdata[r_sel] <= '0;
               end
            end
            S_RD_WAIT: begin
               r_cnt <= r_cnt - 2'd1;
               if (r_cnt == 2'd1) begin
                  r_rdata[r_sel] <= ram_rdata;
                  r_pend[r_sel]  <= 1'b0;
                  r_grant        <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign p0_rdata    = r_rdata[0];
   assign p1_rdata    = r_rdata[1];
   assign p0_rbusy    = r_pend[0] & ~r_wr[0];
   assign p0_wbusy    = r_pend[0] &  r_wr[0];
   assign p1_rbusy    = r_pend[1] & ~r_wr[1];
   assign p1_wbusy    = r_pend[1] &  r_wr[1];
   assign ram_addr    = r_ram_addr;
   assign ram_wdata   = r_ram_wdata;
   assign ram_wen     = r_ram_wen;
   assign ram_rden    = r_ram_rden;
   assign ram_byteena = r_ram_byteena;
   assign grant       = r_grant;
   assign oob_err     = r_oob;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

   localparam int ADDR_W = 10;
   localparam int RD_LAT = 1;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [31:0]       p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]        p0_wmask, p1_wmask;
   logic              p0_rstrb, p1_rstrb;
   logic [31:0]       p0_rdata, p1_rdata;
   logic              p0_rbusy, p0_wbusy, p1_rbusy, p1_wbusy;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;
   logic              ram_wen, ram_rden;
   logic [3:0]        ram_byteena;
   logic [1:0]        grant;
   logic              oob_err;

   int vecs  = 0;
   int fails = 0;
   logic mdl_last;   // port the reference arbiter served last

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .reset_n(reset_n),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask), .p0_rstrb(p0_rstrb),
      .p0_rdata(p0_rdata), .p0_rbusy(p0_rbusy), .p0_wbusy(p0_wbusy),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask), .p1_rstrb(p1_rstrb),
      .p1_rdata(p1_rdata), .p1_rbusy(p1_rbusy), .p1_wbusy(p1_wbusy),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rden(ram_rden),
      .ram_byteena(ram_byteena), .ram_rdata(ram_rdata), .grant(grant), .oob_err(oob_err));

   // RAM IP model: one-cycle read latency, byte-enabled writes
   logic [31:0] mem [1024];
   logic [31:0] ref_mem [1024];
   logic [31:0] model_rdata;
   logic        fix_rd = 1'b0;

   always @(posedge clk) begin
      if (ram_wen)
         for (int b = 0; b < 4; b++)
            if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_rden) model_rdata <= mem[ram_addr];
   end
   assign ram_rdata = fix_rd ? 32'h87654321 : model_rdata;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic drive(input int p, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic r);
      if (p == 0) begin p0_addr = a; p0_wdata = d; p0_wmask = m; p0_rstrb = r; end
      else        begin p1_addr = a; p1_wdata = d; p1_wmask = m; p1_rstrb = r; end
   endtask

   task automatic quiet;
      p0_wmask = 4'h0; p0_rstrb = 1'b0; p1_wmask = 4'h0; p1_rstrb = 1'b0;
   endtask

   task automatic test_reset;
      fix_rd = 1'b1; reset_n = 1'b0; quiet();
      repeat (3) tick();
      vecs++; if ({p0_rdata, p1_rdata} !== 64'h0) begin fails++; $display("FAIL reset_rdata got %h_%h exp 0", p0_rdata, p1_rdata); end
      vecs++; if ({p0_rbusy, p0_wbusy, p1_rbusy, p1_wbusy} !== 4'b0) begin fails++; $display("FAIL reset_busy got %b exp 0000", {p0_rbusy, p0_wbusy, p1_rbusy, p1_wbusy}); end
      vecs++; if ({ram_addr, ram_wdata, ram_wen, ram_rden, ram_byteena} !== '0) begin fails++; $display("FAIL reset_ram got %h %h %b %b %b exp 0", ram_addr, ram_wdata, ram_wen, ram_rden, ram_byteena); end
      vecs++; if ({grant, oob_err} !== 3'b0) begin fails++; $display("FAIL reset_grant got %b/%b exp 0/0", grant, oob_err); end
      reset_n = 1'b1; fix_rd = 1'b0; mdl_last = 1'b1;
      tick();
   endtask

   task automatic test_write;
      drive(0, 32'h4, 32'hABCD1234, 4'hF, 1'b0);
      tick(); quiet();
      vecs++; if ({p0_wbusy, ram_wen, grant} !== 4'b1000) begin fails++; $display("FAIL wr_c1 got wbusy=%b wen=%b grant=%b exp 1 0 00", p0_wbusy, ram_wen, grant); end
      tick();
      vecs++; if ({p0_wbusy, ram_wen, ram_rden, grant} !== 5'b11001) begin fails++; $display("FAIL wr_c2 got wbusy=%b wen=%b rden=%b grant=%b exp 1 1 0 01", p0_wbusy, ram_wen, ram_rden, grant); end
      vecs++; if ({ram_addr, ram_byteena, ram_wdata} !== {10'd1, 4'hF, 32'hABCD1234}) begin fails++; $display("FAIL wr_cmd got %0d %b %h exp 1 1111 abcd1234", ram_addr, ram_byteena, ram_wdata); end
      tick();
      vecs++; if ({p0_wbusy, ram_wen, grant} !== 4'b0000) begin fails++; $display("FAIL wr_c3 got wbusy=%b wen=%b grant=%b exp 0 0 00", p0_wbusy, ram_wen, grant); end
      ref_mem[1] = merge(ref_mem[1], 32'hABCD1234, 4'hF);
      mdl_last = 1'b0;
   endtask

   task automatic test_read;
      int busy_cyc = 0;
      int rden_cyc = 0;
      bit done = 0;
      drive(0, 32'h4, 32'h0, 4'h0, 1'b1);
      for (int c = 0; c < 10 && !done; c++) begin
         tick(); quiet();
         if (ram_rden) begin
            rden_cyc++;
            vecs++; if ({ram_addr, ram_byteena} !== {10'd1, 4'hF}) begin fails++; $display("FAIL rd_cmd got %0d %b exp 1 1111", ram_addr, ram_byteena); end
         end
         if (p0_rbusy) busy_cyc++;
         else begin
            done = 1;
            vecs++; if (p0_rdata !== ref_mem[1]) begin fails++; $display("FAIL rd_data got %h exp %h", p0_rdata, ref_mem[1]); end
         end
      end
      vecs++; if (busy_cyc != RD_LAT + 2 || !done) begin fails++; $display("FAIL rd_busy_len got %0d exp %0d", busy_cyc, RD_LAT + 2); end
      vecs++; if (rden_cyc != 1) begin fails++; $display("FAIL rd_rden_len got %0d exp 1", rden_cyc); end
      mdl_last = 1'b0;
   endtask

   task automatic test_tie;
      int pre [3] = '{0, 0, 1};   // round 3 is preceded by a lone port-1 write
      for (int r = 0; r < 3; r++) begin
         int w0, w1;
         logic first;
         if (pre[r] != 0) begin
            logic [31:0] d;
            d = $urandom;
            drive(1, 32'd300 * 4, d, 4'hF, 1'b0);
            tick(); quiet(); tick(); tick();
            ref_mem[300] = d; mdl_last = 1'b1;
         end
         w0 = $urandom_range(0, 1023); w1 = $urandom_range(0, 1023);
         drive(0, w0 * 4, 32'h0, 4'h0, 1'b1);
         drive(1, w1 * 4, 32'h0, 4'h0, 1'b1);
         first = ~mdl_last;
         tick(); quiet();
         tick();
         vecs++; if (grant !== (first ? 2'b10 : 2'b01)) begin fails++; $display("FAIL tie%0d_first got %b exp port %0d", r, grant, first); end
         repeat (3) tick();
         vecs++; if (grant !== (first ? 2'b01 : 2'b10)) begin fails++; $display("FAIL tie%0d_second got %b exp port %0d", r, grant, ~first); end
         repeat (2) tick();
         vecs++; if ({p0_rbusy, p1_rbusy} !== 2'b00) begin fails++; $display("FAIL tie%0d_busy got %b%b exp 00", r, p0_rbusy, p1_rbusy); end
         vecs++; if ({p0_rdata, p1_rdata} !== {ref_mem[w0], ref_mem[w1]}) begin fails++; $display("FAIL tie%0d_data got %h %h exp %h %h", r, p0_rdata, p1_rdata, ref_mem[w0], ref_mem[w1]); end
         mdl_last = ~first;
      end
   endtask

   task automatic test_write_wins;
      bit saw_rden = 0;
      drive(1, 32'h8, 32'h11223344, 4'b1000, 1'b1);
      tick(); quiet();
      vecs++; if ({p1_wbusy, p1_rbusy} !== 2'b10) begin fails++; $display("FAIL ww_busy got w=%b r=%b exp 1 0", p1_wbusy, p1_rbusy); end
      tick();
      vecs++; if ({ram_wen, ram_byteena, grant, ram_addr} !== {1'b1, 4'b1000, 2'b10, 10'd2}) begin fails++; $display("FAIL ww_cmd got wen=%b be=%b grant=%b addr=%0d exp 1 1000 10 2", ram_wen, ram_byteena, grant, ram_addr); end
      if (ram_rden) saw_rden = 1;
      for (int c = 0; c < 3; c++) begin tick(); if (ram_rden) saw_rden = 1; end
      vecs++; if (saw_rden || p1_rbusy || p1_wbusy) begin fails++; $display("FAIL ww_no_read got rden=%b rbusy=%b wbusy=%b exp 0 0 0", saw_rden, p1_rbusy, p1_wbusy); end
      ref_mem[2] = merge(ref_mem[2], 32'h11223344, 4'b1000);
      drive(1, 32'h8, 32'h0, 4'h0, 1'b1);
      tick(); quiet(); repeat (3) tick();
      vecs++; if (p1_rdata !== ref_mem[2]) begin fails++; $display("FAIL ww_readback got %h exp %h", p1_rdata, ref_mem[2]); end
      mdl_last = 1'b1;
   endtask

   task automatic test_oob;
      drive(0, 32'hFFFFFFFC, 32'h0, 4'h0, 1'b1);
      tick(); quiet();
      vecs++; if (p0_rbusy !== 1'b1) begin fails++; $display("FAIL oob_rbusy got %b exp 1", p0_rbusy); end
      tick();
      vecs++; if ({ram_rden, ram_wen, grant, oob_err} !== 5'b00010) begin fails++; $display("FAIL oob_access got rden=%b wen=%b grant=%b oob=%b exp 0 0 01 0", ram_rden, ram_wen, grant, oob_err); end
      tick();
      vecs++; if ({p0_rbusy, oob_err, p0_rdata} !== {2'b01, 32'h0}) begin fails++; $display("FAIL oob_done got rbusy=%b oob=%b rdata=%h exp 0 1 0", p0_rbusy, oob_err, p0_rdata); end
      tick();
      vecs++; if (oob_err !== 1'b0) begin fails++; $display("FAIL oob_pulse got %b exp 0", oob_err); end
      // out-of-range write aliasing word 0 must leave word 0 untouched
      drive(1, 32'h0000_1000, 32'hDEADBEEF, 4'hF, 1'b0);
      tick(); quiet(); tick();
      vecs++; if ({ram_wen, grant} !== 3'b010) begin fails++; $display("FAIL oobw_access got wen=%b grant=%b exp 0 10", ram_wen, grant); end
      tick();
      vecs++; if ({p1_wbusy, oob_err} !== 2'b01) begin fails++; $display("FAIL oobw_done got wbusy=%b oob=%b exp 0 1", p1_wbusy, oob_err); end
      tick();
      drive(1, 32'h0, 32'h0, 4'h0, 1'b1);
      tick(); quiet(); repeat (3) tick();
      vecs++; if (p1_rdata !== ref_mem[0]) begin fails++; $display("FAIL oobw_nowrite got %h exp %h", p1_rdata, ref_mem[0]); end
      mdl_last = 1'b1;
   endtask

   task automatic test_reset_mid;
      drive(0, 32'h4, 32'h0, 4'h0, 1'b1);
      tick(); quiet(); repeat (3) tick();
      vecs++; if (p0_rdata !== ref_mem[1]) begin fails++; $display("FAIL rm_pre got %h exp %h", p0_rdata, ref_mem[1]); end
      drive(0, 32'h8, 32'h0, 4'h0, 1'b1);
      tick(); quiet(); tick(); tick();
      vecs++; if (p0_rbusy !== 1'b1) begin fails++; $display("FAIL rm_wait got rbusy=%b exp 1", p0_rbusy); end
      reset_n = 1'b0;
      tick();
      vecs++; if ({p0_rbusy, p0_rdata, grant} !== 35'h0) begin fails++; $display("FAIL rm_abort got rbusy=%b rdata=%h grant=%b exp 0 0 00", p0_rbusy, p0_rdata, grant); end
      reset_n = 1'b1; mdl_last = 1'b1;
      tick();
      drive(0, 32'h8, 32'h0, 4'h0, 1'b1);
      tick(); quiet(); repeat (3) tick();
      vecs++; if ({p0_rbusy, p0_rdata} !== {1'b0, ref_mem[2]}) begin fails++; $display("FAIL rm_after got rbusy=%b rdata=%h exp 0 %h", p0_rbusy, p0_rdata, ref_mem[2]); end
   endtask

   // Both ports issue random traffic to disjoint word ranges (port p owns
   // words p*64..p*64+63), with occasional out-of-range requests and junk
   // strobes while pending. Reads are checked against ref_mem; RAM strobes
   // and oob pulses are tallied against what the issued requests imply.
   task automatic test_random;
      bit          outst [2] = '{0, 0};
      bit          is_rd [2];
      logic [31:0] exp_d [2];
      int          age   [2];
      int n_wen = 0, n_rden = 0, n_oob = 0, o_wen = 0, o_rden = 0, o_oob = 0;
      for (int cyc = 0; cyc < 640; cyc++) begin
         tick();
         if (ram_wen) o_wen++;
         if (ram_rden) o_rden++;
         if (oob_err) o_oob++;
         vecs++; if ({ram_wen & ram_rden, grant == 2'b11, (ram_wen | ram_rden) & (grant == 2'b00)} !== 3'b0) begin fails++; $display("FAIL rnd_legal cyc %0d got wen=%b rden=%b grant=%b", cyc, ram_wen, ram_rden, grant); end
         for (int p = 0; p < 2; p++) begin
            logic        busy;
            logic [31:0] rd;
            busy = (p == 0) ? (p0_rbusy | p0_wbusy) : (p1_rbusy | p1_wbusy);
            rd   = (p == 0) ? p0_rdata : p1_rdata;
            if (outst[p]) begin
               if (!busy) begin
                  outst[p] = 0;
                  if (is_rd[p]) begin
                     vecs++; if (rd !== exp_d[p]) begin fails++; $display("FAIL rnd_rdata p%0d cyc %0d got %h exp %h", p, cyc, rd, exp_d[p]); end
                  end
               end else if (++age[p] > 20) begin
                  vecs++; fails++; $display("FAIL rnd_timeout p%0d cyc %0d got busy exp done", p, cyc);
                  outst[p] = 0;
               end
            end
            if (!outst[p] && cyc < 600 && $urandom_range(0, 2) == 0) begin
               bit          oob, wr;
               int          w;
               logic [31:0] a, d;
               logic [3:0]  m;
               oob = ($urandom_range(0, 7) == 0);
               wr  = $urandom_range(0, 1);
               w   = p * 64 + $urandom_range(0, 63);
               a   = oob ? ($urandom | 32'h0000_1000) : (w * 4 + $urandom_range(0, 3));
               d   = $urandom;
               m   = wr ? 4'($urandom_range(1, 15)) : 4'h0;
               drive(p, a, d, m, wr ? 1'($urandom_range(0, 1)) : 1'b1);
               outst[p] = 1; age[p] = 0; is_rd[p] = !wr;
               if (oob) n_oob++;
               if (wr && !oob) begin ref_mem[w] = merge(ref_mem[w], d, m); n_wen++; end
               if (!wr) begin exp_d[p] = oob ? 32'h0 : ref_mem[w]; if (!oob) n_rden++; end
            end else if (outst[p] && $urandom_range(0, 4) == 0) begin
               drive(p, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
            end else begin
               drive(p, $urandom, $urandom, 4'h0, 1'b0);
            end
         end
      end
      quiet();
      vecs++; if (outst[0] || outst[1]) begin fails++; $display("FAIL rnd_drain got outstanding %b%b exp 00", outst[1], outst[0]); end
      vecs++; if (o_wen != n_wen) begin fails++; $display("FAIL rnd_wen_count got %0d exp %0d", o_wen, n_wen); end
      vecs++; if (o_rden != n_rden) begin fails++; $display("FAIL rnd_rden_count got %0d exp %0d", o_rden, n_rden); end
      vecs++; if (o_oob != n_oob) begin fails++; $display("FAIL rnd_oob_count got %0d exp %0d", o_oob, n_oob); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
         ref_mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
      end
      reset_n = 1'b0; mdl_last = 1'b1;
      p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
      quiet();
      test_reset();
      test_write();
      test_read();
      test_tie();
      test_write_wins();
      test_oob();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
